// File: rtl/jk_excite_gen_if.sv
// Pattern handshake bundle for jk_excite_gen.
// master drives pat_valid/pat_data, slave drives pat_ready.
interface jk_excite_gen_if #(
  parameter int WIDTH = 8
);
  logic             pat_valid;
  logic             pat_ready;
  logic [WIDTH-1:0] pat_data;

  modport master (
    output pat_valid,
    output pat_data,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_data,
    output pat_ready
  );
endinterface

// File: rtl/jk_excite_gen.sv
// JK excitation generator: turns a WIDTH-bit target Q pattern (LSB
// first) into one J/K pair per clock for an external JK flop on the
// same clk/rst, tracking the flop's Q in q_model.
// Ports: clk, rst (async, active-high), pat (slave handshake:
// pat_valid/pat_ready/pat_data), J, K, drive_en, q_model, done,
// q_fb (flop Q feedback), err (sticky mismatch flag).
// Optional checker: define JK_EXC_CHECK_EN to compare q_fb against
// q_model; otherwise err is tied low and q_fb is ignored.
module jk_excite_gen #(
  parameter int WIDTH  = 8,
  parameter bit DC_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  jk_excite_gen_if.slave pat,
  output logic           J,
  output logic           K,
  output logic           drive_en,
  output logic           q_model,
  output logic           done,
  input  logic           q_fb,
  output logic           err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             t;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && pat.pat_valid;
  assign t      = sr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // J/K come only from registered state, so they move on clk or rst.
  always_comb begin
    pat.pat_ready = 1'b0;
    drive_en      = 1'b0;
    J             = 1'b0;
    K             = 1'b0;
    if (state == IDLE) begin
      pat.pat_ready = 1'b1;
    end else begin
      drive_en = 1'b1;
      unique case (1'b1)
        (!q_model && !t): begin J = 1'b0;   K = DC_VAL; end
        (!q_model &&  t): begin J = 1'b1;   K = DC_VAL; end
        ( q_model && !t): begin J = DC_VAL; K = 1'b1;   end
        ( q_model &&  t): begin J = DC_VAL; K = 1'b0;   end
        default:          begin J = 1'b0;   K = 1'b0;   end
      endcase
    end
  end

  // q_model is not reinitialised on accept: the next pattern
  // continues from wherever the flop was left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      q_model <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == RUN) && last;
      if (accept) begin
        sr  <= pat.pat_data;
        cnt <= '0;
      end else if (state == RUN) begin
        q_model <= t;
        sr      <= sr >> 1;
        if (!last) cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef JK_EXC_CHECK_EN
  logic chk_arm;

  // Armed in the cycle after each RUN edge, when the flop and
  // q_model should both hold the bit just applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_arm <= 1'b0;
      err     <= 1'b0;
    end else begin
      chk_arm <= (state == RUN);
      if (chk_arm && (q_fb != q_model)) err <= 1'b1;
    end
  end
`else
  logic unused_q_fb;

  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excite_gen.sv
// Directed bench for jk_excite_gen with behavioural JK flops.
// Two instances: DC_VAL=0 and DC_VAL=1.
module tb_jk_excite_gen;

`ifdef JK_EXC_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv = 1'b0;
  logic sel = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  jk_excite_gen_if #(.WIDTH(8)) if0 ();
  jk_excite_gen_if #(.WIDTH(8)) if1 ();

  logic j0, k0, de0, qm0, dn0, er0, fq0, fb0;
  logic j1, k1, de1, qm1, dn1, er1, fq1;

  always #5 clk = ~clk;

  assign fb0 = inv ? ~fq0 : fq0;

  jk_excite_gen #(.WIDTH(8), .DC_VAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .pat(if0.slave),
    .J(j0), .K(k0), .drive_en(de0), .q_model(qm0),
    .done(dn0), .q_fb(fb0), .err(er0)
  );

  jk_excite_gen #(.WIDTH(8), .DC_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .pat(if1.slave),
    .J(j1), .K(k1), .drive_en(de1), .q_model(qm1),
    .done(dn1), .q_fb(fq1), .err(er1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq0 <= 1'b0;
      fq1 <= 1'b0;
    end else begin
      case ({j0, k0})
        2'b01:   fq0 <= 1'b0;
        2'b10:   fq0 <= 1'b1;
        2'b11:   fq0 <= ~fq0;
        default: fq0 <= fq0;
      endcase
      case ({j1, k1})
        2'b01:   fq1 <= 1'b0;
        2'b10:   fq1 <= 1'b1;
        2'b11:   fq1 <= ~fq1;
        default: fq1 <= fq1;
      endcase
    end
  end

  // rdy, J, K, drive_en, q_model, done, flop Q, err
  logic [7:0] ob;
  always_comb begin
    ob = '0;
    if (sel)
      ob = {if1.pat_ready, j1, k1, de1, qm1, dn1, fq1, er1};
    else
      ob = {if0.pat_ready, j0, k0, de0, qm0, dn0, fq0, er0};
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d);
    if (sel) begin
      if1.pat_valid = v;
      if1.pat_data  = d;
    end else begin
      if0.pat_valid = v;
      if0.pat_data  = d;
    end
  endtask

  task automatic chk_rst();
    chk("rst_rdy", ob[7], 1'b1);
    chk("rst_j", ob[6], 1'b0);
    chk("rst_k", ob[5], 1'b0);
    chk("rst_de", ob[4], 1'b0);
    chk("rst_qm", ob[3], 1'b0);
    chk("rst_done", ob[2], 1'b0);
    chk("rst_err", ob[0], 1'b0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge
  // of the done cycle.
  task automatic run_pat(
    input logic       s,
    input logic [7:0] p,
    input logic [7:0] je,
    input logic [7:0] ke,
    input logic       q0,
    input logic       keep,
    input logic [7:0] nxt
  );
    logic qp;
    sel = s;
    drv(1'b1, p);
    #1;
    chk("acc_rdy", ob[7], 1'b1);
    @(negedge clk);
    if (keep) drv(1'b1, nxt);
    else      drv(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      qp = (i == 0) ? q0 : p[i-1];
      chk("run_rdy", ob[7], 1'b0);
      chk("run_j", ob[6], je[i]);
      chk("run_k", ob[5], ke[i]);
      chk("run_de", ob[4], 1'b1);
      chk("run_qm", ob[3], qp);
      chk("run_done", ob[2], 1'b0);
      chk("run_flopq", ob[1], qp);
    end
    @(negedge clk);
    chk("end_done", ob[2], 1'b1);
    chk("end_rdy", ob[7], 1'b1);
    chk("end_de", ob[4], 1'b0);
    chk("end_qm", ob[3], p[7]);
    chk("end_flopq", ob[1], p[7]);
  endtask

  initial begin
    drv(1'b0, 8'h00);
    sel = 1'b1;
    drv(1'b0, 8'h00);
    sel = 1'b0;
    #2;
    chk_rst();
    sel = 1'b1;
    chk_rst();
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 1011_0010 from q=0, DC_VAL=0
    run_pat(1'b0, 8'hB2, 8'h92, 8'h44, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2_done_once", ob[2], 1'b0);
    chk("b2_final_qm", ob[3], 1'b1);

    // 0x55 with DC_VAL=1: toggle every cycle
    run_pat(1'b1, 8'h55, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("t55_done_once", ob[2], 1'b0);
    sel = 1'b0;

    // back-to-back FF then 00 from q=0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    run_pat(1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00);
    run_pat(1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_done_once", ob[2], 1'b0);

    // abandon FF after 3 bits
    drv(1'b1, 8'hFF);
    @(negedge clk);
    drv(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("mid_de", ob[4], 1'b1);
    chk("mid_qm", ob[3], 1'b1);
    rst = 1'b1;
    #1;
    chk_rst();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", ob[2], 1'b0);
    chk("post_rst_de", ob[4], 1'b0);
    run_pat(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00);

    // inverted feedback
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    inv = 1'b1;
    run_pat(1'b0, 8'hB2, 8'h92, 8'h44, 1'b0, 1'b0, 8'h00);
    chk("err_end", ob[0], ERR_EXP);
    @(negedge clk);
    chk("err_sticky", ob[0], ERR_EXP);
    inv = 1'b0;
    @(negedge clk);
    chk("err_sticky2", ob[0], ERR_EXP);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
